// File: rtl/clk_div_if.sv
// Divisor-update handshake between a programming agent and clk_div_prog.
interface clk_div_if #(
    parameter int DIV_WIDTH = 8
);
    logic                 div_valid_i;
    logic                 div_ready_o;
    logic [DIV_WIDTH-1:0] div_i;

    modport master (output div_valid_i, output div_i, input div_ready_o);
    modport slave  (input div_valid_i, input div_i, output div_ready_o);
endinterface

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: glitch-free divided level with near-50% duty,
// divisor changes land only on period boundaries.
module clk_div_prog #(
    parameter int DIV_WIDTH = 8,
    parameter int RESET_DIV = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    clk_div_if.slave             bus,
    output logic                 clk_div_o,
    output logic                 edge_o,
    output logic [DIV_WIDTH-1:0] cur_div_o
);
    localparam logic [DIV_WIDTH-1:0] TWO   = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0] RST_D = (RESET_DIV < 2) ? TWO : DIV_WIDTH'(RESET_DIV);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state;
    logic [DIV_WIDTH-1:0] d, p, cnt;
    logic                 pend;
    logic [DIV_WIDTH:0]   h, cnt_nxt;
    logic                 boundary, accept;

    function automatic logic [DIV_WIDTH-1:0] clamp(input logic [DIV_WIDTH-1:0] v);
        return (v < TWO) ? TWO : v;
    endfunction

    // Widened by one bit so H and cnt+1 stay exact at D = 2^DIV_WIDTH-1.
    assign h        = ({1'b0, d} + {{DIV_WIDTH{1'b0}}, 1'b1}) >> 1;
    assign cnt_nxt  = {1'b0, cnt} + {{DIV_WIDTH{1'b0}}, 1'b1};
    assign boundary = (state == RUN) && (cnt == d - 1'b1);
    assign accept   = bus.div_valid_i && !pend;

    assign bus.div_ready_o = !pend;
    assign cur_div_o       = d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            d         <= RST_D;
            p         <= '0;
            pend      <= 1'b0;
            clk_div_o <= 1'b0;
            edge_o    <= 1'b0;
        end else begin
            edge_o <= 1'b0;
            case (state)
                IDLE: begin
                    cnt       <= '0;
                    clk_div_o <= 1'b0;
                    if (accept) d <= clamp(bus.div_i);
                    if (en_i) begin
                        state     <= RUN;
                        clk_div_o <= 1'b1;
                        edge_o    <= 1'b1;
                    end
                end
                RUN: begin
                    if (boundary) begin
                        // A pending value outranks a fresh offer; ready is low then anyway.
                        if (pend) begin
                            d    <= p;
                            pend <= 1'b0;
                        end else if (accept) begin
                            d <= clamp(bus.div_i);
                        end
                        cnt <= '0;
                        if (en_i) begin
                            clk_div_o <= 1'b1;
                            edge_o    <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            clk_div_o <= 1'b0;
                        end
                    end else begin
                        if (accept) begin
                            p    <= clamp(bus.div_i);
                            pend <= 1'b1;
                        end
                        cnt       <= cnt_nxt[DIV_WIDTH-1:0];
                        clk_div_o <= (cnt_nxt < h);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
